data_memory_lsu: RTL

//  Byte-addressed RV32 data memory with a request/response handshake, replacing the word-addressed array.

---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_byte_ram.sv | 33 +++
 rtl/data_memory_lsu.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed RV32 data memory.
// Decodes funct3/offset into byte enables and the misaligned/illegal flags.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } dmem_state_e;

   typedef struct packed {
      logic [3:0] be;
      logic       misaligned;
   } dmem_lane_t;

   // funct3[1:0] carries the access size for both loads and stores.
   function automatic dmem_lane_t dmem_lanes(input logic [2:0] f3, input logic [1:0] off);
      dmem_lane_t r;
      r.be         = 4'b0000;
      r.misaligned = 1'b0;
      case (f3[1:0])
         2'b00: r.be = 4'b0001 << off;
         2'b01: begin
            r.be         = 4'b0011 << off;
            r.misaligned = off[0];
         end
         2'b10: begin
            r.be         = 4'b1111;
            r.misaligned = (off != 2'b00);
         end
         default: r.be = 4'b0000;
      endcase
      return r;
   endfunction

   function automatic logic dmem_illegal(input logic we, input logic [2:0] f3);
      if (we) begin
         return (f3 > F3_W);
      end
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port synchronous RAM, four byte lanes with per-lane write enable.
// Read data is registered and only updates when the port is enabled.
module dmem_byte_ram #(
   parameter int unsigned AddrWidth = 11,
   parameter string       InitFile  = ""
) (
   input  logic                 clk_i,
   input  logic                 en_i,
   input  logic                 we_i,
   input  logic [3:0]           be_i,
   input  logic [AddrWidth-1:0] addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o
);

   localparam int unsigned Words = 2 ** AddrWidth;

   logic [31:0] mem_q [Words];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int l = 0; l < 4; l++) begin
               if (be_i[l]) begin
                  mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
               end
            end
         end
         rdata_o <= mem_q[addr_i];
      end
   end

endmodule

// File: rtl/data_memory_lsu.sv
// RV32 load/store unit in front of a byte-lane RAM: request latch, wait-state FSM,
// load extension and misaligned/illegal reporting with a one-cycle response pulse.
module data_memory_lsu
   import dmem_pkg::*;
#(
   parameter int unsigned P_ADDR_WIDTH  = 13,
   parameter int unsigned P_DATA_WIDTH  = 32,
   parameter int unsigned P_WAIT_STATES = 0,
   parameter string       P_INIT_FILE   = ""
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req,
   output logic                    o_ready,
   input  logic                    i_we,
   input  logic [P_ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]              i_f3,
   input  logic [31:0]             i_wdata,
   output logic                    o_rvalid,
   output logic [31:0]             o_rdata,
   output logic                    o_misaligned,
   output logic                    o_illegal
);

   if (P_DATA_WIDTH != 32) begin : g_width_check
      $error("data_memory_lsu supports only P_DATA_WIDTH = 32");
   end
   if (P_WAIT_STATES > 15) begin : g_wait_check
      $error("data_memory_lsu supports P_WAIT_STATES in 0..15");
   end

   localparam logic [3:0] CntLoad = (P_WAIT_STATES > 0) ? 4'(P_WAIT_STATES - 1) : 4'd0;

   dmem_state_e state_q;
   logic [3:0]  cnt_q;
   logic        ready_q, rvalid_q;
   logic        we_q, mis_q, ill_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] hold_rdata_q;
   logic        hold_mis_q, hold_ill_q;

   logic        accept, req_ill, req_mis, wr_en;
   dmem_lane_t  lane;
   logic [31:0] wr_data, ram_rdata, resp_data;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   assign accept  = i_req & ready_q;
   assign lane    = dmem_lanes(i_f3, i_addr[1:0]);
   assign req_ill = dmem_illegal(i_we, i_f3);
   assign req_mis = lane.misaligned & ~req_ill;
   assign wr_en   = accept & i_we & ~req_ill & ~req_mis;

   // Replicate store data across lanes; the byte enables pick the right copy.
   always_comb begin
      wr_data = i_wdata;
      case (i_f3[1:0])
         2'b00:   wr_data = {4{i_wdata[7:0]}};
         2'b01:   wr_data = {2{i_wdata[15:0]}};
         default: wr_data = i_wdata;
      endcase
   end

   dmem_byte_ram #(
      .AddrWidth (P_ADDR_WIDTH - 2),
      .InitFile  (P_INIT_FILE)
   ) u_ram (
      .clk_i   (i_clk),
      .en_i    (accept),
      .we_i    (wr_en),
      .be_i    (lane.be),
      .addr_i  (i_addr[P_ADDR_WIDTH-1:2]),
      .wdata_i (wr_data),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         we_q     <= 1'b0;
         f3_q     <= 3'b000;
         off_q    <= 2'b00;
         mis_q    <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         if (accept) begin
            we_q  <= i_we;
            f3_q  <= i_f3;
            off_q <= i_addr[1:0];
            mis_q <= req_mis;
            ill_q <= req_ill;
         end
         if (P_WAIT_STATES == 0) begin
            rvalid_q <= accept;
         end else begin
            rvalid_q <= 1'b0;
            unique case (state_q)
               StIdle: begin
                  if (accept) begin
                     state_q <= StWait;
                     cnt_q   <= CntLoad;
                     ready_q <= 1'b0;
                  end
               end
               StWait: begin
                  if (cnt_q == 4'd0) begin
                     state_q  <= StResp;
                     rvalid_q <= 1'b1;
                     ready_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - 4'd1;
                  end
               end
               StResp: begin
                  if (accept) begin
                     state_q <= StWait;
                     cnt_q   <= CntLoad;
                     ready_q <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      rd_byte   = ram_rdata[{off_q, 3'b000} +: 8];
      rd_half   = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
      resp_data = 32'd0;
      if (!we_q && !mis_q && !ill_q) begin
         case (f3_q)
            F3_B:    resp_data = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   resp_data = {24'd0, rd_byte};
            F3_H:    resp_data = {{16{rd_half[15]}}, rd_half};
            F3_HU:   resp_data = {16'd0, rd_half};
            F3_W:    resp_data = ram_rdata;
            default: resp_data = 32'd0;
         endcase
      end
   end

   // Outputs track the live response only in the valid cycle, otherwise replay it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         hold_rdata_q <= 32'd0;
         hold_mis_q   <= 1'b0;
         hold_ill_q   <= 1'b0;
      end else if (rvalid_q) begin
         hold_rdata_q <= resp_data;
         hold_mis_q   <= mis_q;
         hold_ill_q   <= ill_q;
      end
   end

   assign o_ready      = ready_q;
   assign o_rvalid     = rvalid_q;
   assign o_rdata      = rvalid_q ? resp_data : hold_rdata_q;
   assign o_misaligned = rvalid_q ? mis_q : hold_mis_q;
   assign o_illegal    = rvalid_q ? ill_q : hold_ill_q;

endmodule
